// File: rtl/div_repsub.sv
// ============================================================================
// div_repsub : unsigned repeated-subtraction divider, serial operand load.
// Optional cycle counter output enabled by macro DIV_REPSUB_CYCLE_CNT_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module div_repsub #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             done,
  output logic             busy,
  output logic             div_by_zero
`ifdef DIV_REPSUB_CYCLE_CNT_EN
  ,
  output logic [WIDTH+1:0] cycle_cnt
`endif
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOAD_B = 2'd1,
    S_RUN    = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  localparam logic [WIDTH-1:0] c_Q_ONE = WIDTH'(1);

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_quot;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_b;
  logic             r_dbz;
  logic             w_b_zero;
  logic             w_rem_ge;

  assign w_b_zero = (r_b == '0);
  assign w_rem_ge = (r_rem >= r_b);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_DONE: if (start) w_next = S_LOAD_B;
      S_LOAD_B:       w_next = S_RUN;
      S_RUN:          if (w_b_zero || !w_rem_ge) w_next = S_DONE;
      default:        w_next = S_IDLE;
    endcase
  end

  // Remainder register starts as the dividend and is whittled down in RUN.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_quot <= '0;
      r_rem  <= '0;
      r_b    <= '0;
      r_dbz  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_rem  <= data_in;
            r_quot <= '0;
            r_dbz  <= 1'b0;
          end
        end
        S_LOAD_B: r_b <= data_in;
        S_RUN: begin
          if (w_b_zero) begin
            r_dbz <= 1'b1;
          end else if (w_rem_ge) begin
            r_rem  <= r_rem - r_b;
            r_quot <= r_quot + c_Q_ONE;
          end
        end
        default: ;
      endcase
    end
  end

  assign quotient    = r_quot;
  assign remainder   = r_rem;
  assign div_by_zero = r_dbz;
  assign done        = (r_state == S_DONE);
  assign busy        = (r_state == S_LOAD_B) || (r_state == S_RUN);

`ifdef DIV_REPSUB_CYCLE_CNT_EN
  localparam logic [WIDTH+1:0] c_CNT_ONE = (WIDTH+2)'(1);
  logic [WIDTH+1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if ((r_state == S_IDLE || r_state == S_DONE) && start) begin
      r_cnt <= '0;
    end else if (busy) begin
      r_cnt <= r_cnt + c_CNT_ONE;
    end
  end

  assign cycle_cnt = r_cnt;
`else
  // Counter absent in this build.
`endif

endmodule

`default_nettype wire

// File: doc/div_repsub.md
Name: div_repsub

Overview:
- Unsigned integer divider using repeated subtraction, with a datapath and FSM controller in one module. It is the inverse of the team's repeated-addition multiplier.
- Operands arrive serially on one shared data_in bus, dividend first and divisor second, after a start request.
- Results are quotient and remainder, flagged by a level done. The block sits beside the multiplier in the arithmetic datapath library and uses the same start/data_in/done operand protocol.

Parameters:
- WIDTH, 16, bit width of data_in, dividend, divisor, quotient and remainder.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled in IDLE or DONE.
- data_in  input  WIDTH  operand bus; dividend on the start edge, divisor on the following edge.
- quotient  output  WIDTH  result quotient, valid while done=1.
- remainder  output  WIDTH  result remainder, valid while done=1.
- done  output  1  high while in DONE.
- busy  output  1  high in LOAD_B and RUN.
- div_by_zero  output  1  high in DONE when divisor was 0.

Behaviour:
- Reset (asynchronous, active-high):
  - state=IDLE.
  - quotient, remainder, internal divisor register B, done, busy and div_by_zero all 0.
  - Reset asserted mid-operation aborts immediately; there is no partial result.
- IDLE:
  - start=1 at an edge: remainder<=data_in (dividend), quotient<=0, div_by_zero<=0 -> LOAD_B.
  - Otherwise stay.
- LOAD_B: B<=data_in unconditionally -> RUN. start is ignored.
- RUN, one decision per edge, in this priority:
  1. B==0: div_by_zero<=1, quotient=0, remainder=dividend -> DONE.
  2. remainder>=B: remainder<=remainder-B, quotient<=quotient+1, stay in RUN.
  3. Otherwise -> DONE.
- DONE:
  - done=1; quotient, remainder and div_by_zero are held.
  - start=1 at an edge behaves exactly as start in IDLE: captures a new dividend, clears quotient and div_by_zero, done falls -> LOAD_B.
  - start=0 -> stay in DONE indefinitely.
- Outputs are registered or decoded from the state register; no combinational path from start or data_in to any output.
- Latency, counted in edges from the start-sampling edge to the edge after which done=1:
  - Q+3, where Q is the final quotient.
  - 3 for divisor 0.
  - Worst case 2^WIDTH+2 (dividend all-ones, divisor 1).
- Width rules:
  - Comparison and subtraction are unsigned at WIDTH bits.
  - The quotient cannot overflow because Q<=dividend<=2^WIDTH-1.
  - remainder<B always holds at DONE when B!=0.
- Boundary cases:
  - Dividend < divisor: quotient 0, remainder=dividend, latency 3.
  - Dividend == divisor: quotient 1, remainder 0, latency 4.
  - Dividend 0, divisor nonzero: quotient 0, remainder 0, div_by_zero 0, latency 3.
  - Dividend 0, divisor 0: div_by_zero 1, quotient 0, remainder 0.
  - start held high continuously: one operation per pass. DONE lasts exactly one cycle before the next capture, and data_in at that edge is taken as the next dividend.

Optional Feature:
- Macro: DIV_REPSUB_CYCLE_CNT_EN.
- Defined:
  - Extra output port cycle_cnt (WIDTH+2 bits).
  - Cleared on reset and on each start capture; increments by 1 on every edge spent in LOAD_B or RUN; held in DONE.
  - At DONE it equals Q+2, or 2 for divisor 0.
- Undefined: the port and its counter do not exist. All other behaviour is identical.

Test Plan:
- Reset, then start=1 with data_in=17 on the start edge and 5 on the next edge -> after 6 edges: done=1, quotient=3, remainder=2, div_by_zero=0, busy=0. With the macro defined, cycle_cnt=5.
- Dividend 9, divisor 0 -> after 3 edges: done=1, div_by_zero=1, quotient=0, remainder=9. Values hold for 10 further cycles with start=0.
- Dividend 4, divisor 7 -> done after 3 edges, quotient=0, remainder=4. Then dividend 7, divisor 7 -> done after 4 edges, quotient=1, remainder=0.
- Assert rst asynchronously (mid-clock) during RUN of 1000/3 -> all outputs 0 immediately, state IDLE. A following 1000/3 completes with quotient=333, remainder=1 in 336 edges.
- start held high across two back-to-back operations (20/6 then 65535/1) -> first result quotient=3, remainder=2, with done high for exactly one cycle. Second result quotient=65535, remainder=0 after 65538 edges.
- Pulse start during LOAD_B and RUN of 50/7 -> ignored: result quotient=7, remainder=1, latency 10.
